data_pack: RTL and testbench
============================

# data_pack

Gearbox packer that accumulates narrow IN_WIDTH-bit symbols into wide OUT_WIDTH-bit words, MSB-first, with no gaps between symbols. It is the transmit-side counterpart of the 32→7 unpacker: a symbol stream packed here and unpacked there reproduces the original symbol sequence. Both sides use valid/ready flow control. A flush request emits a final zero-padded partial word marked with `last_out` and a valid-bit count.

## Interface
- IN_WIDTH, 7, symbol width; 1 ≤ IN_WIDTH ≤ OUT_WIDTH
- OUT_WIDTH, 32, packed word width
- clk  in  1  single clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  symbol present on data_in
- ready_in  out  1  packer accepts a symbol this cycle (combinational)
- data_in  in  IN_WIDTH  symbol; bit IN_WIDTH-1 is sent first
- flush_in  in  1  request to drain the accumulator
- valid_out  out  1  word present on data_out (registered)
- ready_out  in  1  downstream accepts the word
- data_out  out  OUT_WIDTH  packed word; the earliest bit is at the MSB
- bits_out  out  $clog2(OUT_WIDTH+1)  number of meaningful bits in data_out, counted from the MSB
- last_out  out  1  data_out is the final word of a flush
- busy  out  1  flush in progress

## Operation
- Accumulator `acc` has width A = OUT_WIDTH+IN_WIDTH-1 and is left-justified. Valid bits occupy acc[A-1 : A-fill]. The fill counter covers 0..A.
- Accept rule: a symbol is accepted when valid_in && ready_in. It is appended directly below the existing valid bits, and fill increases by IN_WIDTH.
- ready_in = !rst && state==RUN && fill < OUT_WIDTH. Under this rule the accumulator never overflows.
- Output slot: a single register holding data_out, bits_out, last_out and valid_out. The slot is free when !valid_out || ready_out.
- Extract rule: when fill ≥ OUT_WIDTH and the slot is free:
  - acc[A-1 : A-OUT_WIDTH] moves to data_out; bits_out=OUT_WIDTH; valid_out=1.
  - acc shifts left by OUT_WIDTH; fill decreases by OUT_WIDTH.
- Same-cycle accept and extract: the result equals extract-then-append, so fill' = fill+IN_WIDTH-OUT_WIDTH. This cannot happen with the default widths, because ready_in is low whenever fill ≥ OUT_WIDTH.
- If the slot is free and nothing is extracted, valid_out clears. A word held with ready_out low stays stable: data_out, bits_out and last_out do not change.
- FSM states: RUN and FLUSH.
  - RUN→FLUSH when flush_in=1. A symbol accepted in that same cycle is part of the flush.
  - In FLUSH: ready_in=0 and busy=1. flush_in is ignored.
  - Full words extract normally in FLUSH.
  - If extracting a full word leaves fill=0, that word carries last_out=1, and the state returns to RUN.
  - If 0 < fill < OUT_WIDTH and the slot is free, emit a partial word:
    - data_out = acc top bits, zero-padded in the LSBs;
    - bits_out=fill; last_out=1;
    - fill←0, acc←0, then RUN.
  - If FLUSH is entered with fill=0: no word is emitted, and the state returns to RUN on the next edge.
- Non-final words always carry last_out=0.

## Timing
- Reset: valid_out=0, data_out=0, bits_out=0, last_out=0, busy=0, fill=0, acc=0, state=RUN.
  - ready_in=0 while rst=1, and 1 in the first cycle after reset.
  - Reset mid-flush or mid-word discards all buffered bits, including any held output word.
- Latency: the word completed by the symbol accepted at edge N is loaded at edge N+1. valid_out is high from N+1, provided the slot is free.
- Default widths:
  - ready_in drops for one cycle after each word completes.
  - Sustained input: 32 symbols (224 bits) in 39 cycles, with ready_out held at 1.
- Back-pressure: with ready_out=0 and a word held, fill may rise to A-… up to OUT_WIDTH-1+IN_WIDTH. ready_in stays low once fill ≥ OUT_WIDTH.
- FLUSH with fill=0 and a held word: the held word is not modified. busy drops after one cycle.
- ready_in never depends on ready_out combinationally; it is decoded from registers only.

## Test plan
- Pack 5 symbols: send 1, 2, 3, 4, 5 with ready_out=1.
  - Required: one word 0x02081840, bits_out=32, last_out=0, fill=3.
  - Then pulse flush_in: word 0xA0000000, bits_out=3, last_out=1, and busy high for the flush.
- Pack 32 symbols of 0x7F back-to-back.
  - Required: 7 words of 0xFFFFFFFF; the 7th has last_out=0; fill=0 at the end; ready_in drops 7 times.
  - Then flush: no word emitted, busy high for 1 cycle.
- Back-pressure: hold ready_out=0 while streaming.
  - Required: the first word stays stable, and ready_in falls once fill ≥ 32.
  - Release ready_out: words continue with no bit lost or duplicated. Compare against a reference packer over 1000 random symbols.
- Flush exactly on a boundary: send 32 symbols of alternating 0x55/0x2A, asserting flush_in together with the 32nd valid_in.
  - Required: 7 words; the last has last_out=1 and bits_out=32; no partial word follows.
- Reset mid-operation: feed 3 symbols, assert rst for 1 cycle, then feed 1, 2, 3, 4, 5.
  - Required: all outputs are 0 during reset, and the first word after reset is 0x02081840.
- Loopback: packer output feeds the 32→7 unpacker with random stalls on both sides.
  - Required: 10,000 random symbols emerge in order, bit-exact.

Source files
------------

// File: rtl/data_pack.sv
// data_pack: MSB-first gearbox packer, IN_WIDTH-bit symbols into OUT_WIDTH-bit words.
// A flush drains the accumulator as a zero-padded final word tagged with last_out.
module data_pack #(
  parameter int IN_WIDTH  = 7,
  parameter int OUT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_in,
  output logic                           ready_in,
  input  logic [IN_WIDTH-1:0]            data_in,
  input  logic                           flush_in,
  output logic                           valid_out,
  input  logic                           ready_out,
  output logic [OUT_WIDTH-1:0]           data_out,
  output logic [$clog2(OUT_WIDTH+1)-1:0] bits_out,
  output logic                           last_out,
  output logic                           busy
);

  localparam int A  = OUT_WIDTH + IN_WIDTH - 1;
  localparam int FW = $clog2(A + 1);
  localparam int BW = $clog2(OUT_WIDTH + 1);
  localparam logic [FW-1:0] OW_F = FW'(OUT_WIDTH);
  localparam logic [FW-1:0] IW_F = FW'(IN_WIDTH);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [A-1:0]         acc_q, acc_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [BW-1:0]        bits_q, bits_d;
  logic                 last_q, last_d;
  logic                 valid_q, valid_d;

  logic         slot_free;
  logic         accept;
  logic         extract;
  logic         partial;
  logic [A-1:0] sym_ext;

  assign slot_free = !valid_q || ready_out;
  assign ready_in  = !rst && (state_q == RUN) && (fill_q < OW_F);
  assign accept    = valid_in && ready_in;
  assign extract   = (fill_q >= OW_F) && slot_free;
  assign partial   = (state_q == FLUSH) && (fill_q != '0)
                     && (fill_q < OW_F) && slot_free;
  assign sym_ext   = A'(data_in) << (A - IN_WIDTH);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    data_d  = data_q;
    bits_d  = bits_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (slot_free) valid_d = 1'b0;
    unique case (1'b1)
      extract: begin
        data_d  = acc_q[A-1 -: OUT_WIDTH];
        bits_d  = BW'(OUT_WIDTH);
        last_d  = (state_q == FLUSH) && (fill_q == OW_F);
        valid_d = 1'b1;
        acc_d   = acc_q << OUT_WIDTH;
        fill_d  = fill_q - OW_F;
      end
      partial: begin
        data_d  = acc_q[A-1 -: OUT_WIDTH];
        bits_d  = BW'(fill_q);
        last_d  = 1'b1;
        valid_d = 1'b1;
        acc_d   = '0;
        fill_d  = '0;
      end
      default: ;
    endcase
    // Append below whatever survives the extract.
    if (accept) begin
      acc_d  = acc_d | (sym_ext >> fill_d);
      fill_d = fill_d + IW_F;
    end
    if (state_q == RUN) begin
      if (flush_in) state_d = FLUSH;
    end else begin
      if (partial || (fill_q == '0) || (extract && (fill_q == OW_F)))
        state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      bits_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      bits_q  <= bits_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign bits_out  = bits_q;
  assign last_out  = last_q;
  assign busy      = (state_q == FLUSH);

endmodule

// File: tb/tb_data_pack.sv
// tb_data_pack: randomized scoreboard bench for the data_pack gearbox packer.
// A bit-queue reference model predicts every word; a monitor pops and compares.
module tb_data_pack;
  localparam int IW = 7;
  localparam int OW = 32;
  localparam int BW = $clog2(OW + 1);

  typedef struct {
    logic [OW-1:0] d;
    int            b;
    bit            l;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic          flush_in = 1'b0;
  logic          ready_out = 1'b1;
  logic [IW-1:0] data_in = '0;
  logic          ready_in, valid_out, last_out, busy;
  logic [OW-1:0] data_out;
  logic [BW-1:0] bits_out;

  int    ncmp = 0;
  int    nerr = 0;
  word_t expq[$];
  word_t gotq[$];
  bit    bq[$];
  bit    rand_ro = 1'b0;
  logic  ro_fixed = 1'b1;
  logic  held_v = 1'b0;
  logic [OW+BW+1:0] held_w = '0;

  data_pack #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_in(ready_in),
    .data_in(data_in), .flush_in(flush_in),
    .valid_out(valid_out), .ready_out(ready_out),
    .data_out(data_out), .bits_out(bits_out),
    .last_out(last_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Downstream acceptance, random or fixed.
  initial forever begin
    @(posedge clk);
    #2;
    ready_out = rand_ro ? ($urandom_range(0, 2) != 0) : ro_fixed;
  end

  // Reference model: flat bit stream cut into words.
  always @(negedge clk) begin
    if (rst) begin
      bq.delete();
      expq.delete();
    end else begin
      if (valid_in && ready_in)
        for (int i = IW - 1; i >= 0; i--) bq.push_back(data_in[i]);
      while (bq.size() >= OW) begin
        word_t w;
        w.d = '0;
        for (int i = 0; i < OW; i++) w.d = {w.d[OW-2:0], bq.pop_front()};
        w.b = OW;
        w.l = flush_in && (bq.size() == 0);
        expq.push_back(w);
      end
      if (flush_in && (bq.size() > 0)) begin
        word_t w;
        w.d = '0;
        w.b = bq.size();
        for (int i = 0; i < OW; i++)
          w.d = {w.d[OW-2:0], (i < w.b) ? bq[i] : 1'b0};
        w.l = 1'b1;
        bq.delete();
        expq.push_back(w);
      end
    end
  end

  // Monitor: compare every handshaken word, and check held words stay put.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v)
        chk("hold_stable", 64'({valid_out, last_out, bits_out, data_out}),
            64'(held_w));
      if (valid_out && ready_out) begin
        word_t g;
        word_t e;
        g.d = data_out;
        g.b = int'(bits_out);
        g.l = last_out;
        gotq.push_back(g);
        if (expq.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL unexpected_word: got %h bits %0d last %0d, none expected",
                   data_out, bits_out, last_out);
        end else begin
          e = expq.pop_front();
          chk("word", 64'({last_out, bits_out, data_out}),
              64'({e.l, BW'(e.b), e.d}));
        end
      end
      held_v = valid_out && !ready_out;
      held_w = {valid_out, last_out, bits_out, data_out};
    end
  end

  task automatic send(input logic [IW-1:0] s, input logic fl);
    int n = 0;
    while (!ready_in && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ready_in) begin
      ncmp++;
      nerr++;
      $display("FAIL send_timeout: ready_in %0d required 1", ready_in);
    end else begin
      valid_in = 1'b1;
      data_in  = s;
      flush_in = fl;
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    flush_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || valid_out || busy) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      ncmp++;
      nerr++;
      $display("FAIL drain_timeout: %0d words pending, required 0", expq.size());
    end
  endtask

  task automatic pulse_flush();
    flush_in = 1'b1;
    @(posedge clk);
    #1;
    flush_in = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, lows, bcnt, rh;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", 64'({valid_out, last_out, busy, bits_out, data_out}), 64'd0);
    chk("rst_ready", 64'(ready_in), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(ready_in), 64'd1);
    @(posedge clk);
    #1;

    // Five symbols, then flush the 3-bit tail.
    gotq.delete();
    for (int i = 1; i <= 5; i++) send(IW'(i), 1'b0);
    pulse_flush();
    chk("t1_busy", 64'(busy), 64'd1);
    drain();
    chk("t1_count", 64'(gotq.size()), 64'd2);
    if (gotq.size() == 2) begin
      chk("t1_w0", 64'({gotq[0].l, BW'(gotq[0].b), gotq[0].d}),
          64'({1'b0, BW'(32), 32'h02081840}));
      chk("t1_w1", 64'({gotq[1].l, BW'(gotq[1].b), gotq[1].d}),
          64'({1'b1, BW'(3), 32'hA0000000}));
    end

    // Sustained 0x7F: 32 symbols in 39 cycles, 7 ready drops.
    gotq.delete();
    sent = 0;
    lows = 0;
    for (int c = 0; c < 39; c++) begin
      if (ready_in && sent < 32) begin
        valid_in = 1'b1;
        data_in  = 7'h7F;
        sent++;
      end else begin
        valid_in = 1'b0;
        if (!ready_in) lows++;
      end
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    chk("t2_sent", 64'(sent), 64'd32);
    chk("t2_ready_drops", 64'(lows), 64'd7);
    drain();
    chk("t2_count", 64'(gotq.size()), 64'd7);
    for (int i = 0; i < gotq.size(); i++)
      chk("t2_word", 64'({gotq[i].l, gotq[i].d}), 64'({1'b0, 32'hFFFFFFFF}));
    pulse_flush();
    bcnt = int'(busy);
    repeat (3) begin
      @(posedge clk);
      #1;
      bcnt += int'(busy);
    end
    chk("t2_empty_flush_busy", 64'(bcnt), 64'd1);
    chk("t2_no_extra_word", 64'(gotq.size()), 64'd7);

    // Back-pressure: first word held, ready_in stays low.
    ro_fixed = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) send(IW'($urandom), 1'b0);
    rh = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      rh += int'(ready_in);
    end
    chk("t3_ready_low", 64'(rh), 64'd0);
    chk("t3_held_valid", 64'(valid_out), 64'd1);
    ro_fixed = 1'b1;
    drain();

    // Random stream with random stalls and occasional flushes.
    rand_ro = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(IW'($urandom), ($urandom_range(0, 39) == 0));
    end
    rand_ro = 1'b0;
    ro_fixed = 1'b1;
    drain();
    pulse_flush();
    drain();

    // Flush together with the word-completing 32nd symbol.
    gotq.delete();
    for (int i = 0; i < 32; i++)
      send((i % 2 == 1) ? 7'h2A : 7'h55, (i == 31));
    drain();
    chk("t4_count", 64'(gotq.size()), 64'd7);
    if (gotq.size() == 7)
      chk("t4_last", 64'({gotq[6].l, BW'(gotq[6].b), gotq[6].d}),
          64'({1'b1, BW'(32), 32'hAAAAAAAA}));

    // Reset mid-word discards buffered bits.
    for (int i = 0; i < 3; i++) send(IW'($urandom), 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_ready_in_rst", 64'(ready_in), 64'd0);
    @(posedge clk);
    #1;
    chk("t5_rst_outputs", 64'({valid_out, last_out, busy, bits_out, data_out}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    gotq.delete();
    for (int i = 1; i <= 5; i++) send(IW'(i), 1'b0);
    drain();
    chk("t5_count", 64'(gotq.size()), 64'd1);
    if (gotq.size() >= 1)
      chk("t5_first_word", 64'(gotq[0].d), 64'h02081840);
    pulse_flush();
    drain();

    chk("final_queue_empty", 64'(expq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
